axis_egress_fifo: RTL and testbench



---
 rtl/axi4_pkg.sv | 23 ++
 rtl/axi_stream_interface.sv | 17 +
 rtl/fifo_ptr_ctrl.sv | 46 ++++
 rtl/axis_egress_fifo.sv | 104 ++++++++++
 tb/tb_axis_egress_fifo.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions: AXI4-Stream beat layout and egress FIFO defaults.
package axi4_pkg;

  localparam int unsigned AXIS_DATA_W   = 64;
  localparam int unsigned AXIS_STRB_W   = 8;
  localparam int unsigned AXIS_DEST_W   = 4;
  localparam int unsigned AXIS_USER_W   = 8;
  localparam int unsigned AXIS_ID_W     = 8;
  localparam int unsigned AXIS_BEAT_WIDTH = 101;
  localparam int unsigned AXIS_EGRESS_DEPTH_DEFAULT = 16;

  // Stored beat, MSB to LSB
  typedef struct packed {
    logic                   tlast;
    logic [AXIS_STRB_W-1:0] tkeep;
    logic [AXIS_STRB_W-1:0] tstrb;
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_DEST_W-1:0] tdest;
    logic [AXIS_USER_W-1:0] tuser;
    logic [AXIS_ID_W-1:0]   tid;
  } axis_beat_t;

endpackage

// File: rtl/axi_stream_interface.sv
// AXI4-Stream bundle used between the NoC bridge, egress FIFO and endpoint.
interface axi_stream_interface;
  logic [63:0] tdata;
  logic [7:0]  tstrb;
  logic [7:0]  tkeep;
  logic        tlast;
  logic [3:0]  tdest;
  logic [7:0]  tuser;
  logic [7:0]  tid;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tstrb, tkeep, tlast, tdest, tuser, tid, tvalid,
                  input  tready);
  modport slave  (input  tdata, tstrb, tkeep, tlast, tdest, tuser, tid, tvalid,
                  output tready);
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Write/read pointers and occupancy count for a power-of-2 FIFO.
// Callers must only assert i_wr_en when not full and i_rd_en when not empty.
module fifo_ptr_ctrl #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     i_wr_en,
  input  logic                     i_rd_en,
  output logic [$clog2(DEPTH)-1:0] o_wr_ptr,
  output logic [$clog2(DEPTH)-1:0] o_rd_ptr,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full_c,
  output logic                     o_empty_c
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally at DEPTH since DEPTH is a power of 2
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_wr_en, i_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_wr_ptr  = r_wr_ptr;
  assign o_rd_ptr  = r_rd_ptr;
  assign o_count   = r_count;
  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);

endmodule

// File: rtl/axis_egress_fifo.sv
// AXI4-Stream egress beat buffer between the NoC slave bridge and the endpoint.
// Define AXIS_EGRESS_PACKET_MODE_EN for store-and-forward; default is cut-through.
module axis_egress_fifo
  import axi4_pkg::*;
#(
  parameter int unsigned DEPTH        = AXIS_EGRESS_DEPTH_DEFAULT,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  axi_stream_interface.slave     s_axis,
  axi_stream_interface.master    m_axis,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   almost_full
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  axis_beat_t       r_mem [DEPTH];
  axis_beat_t       w_wr_beat;
  axis_beat_t       w_rd_beat;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_out_valid;

  // Ready depends on stored state only, never on the consumer
  assign s_axis.tready = !w_full;
  assign w_in_fire     = s_axis.tvalid && !w_full;
  assign w_out_fire    = w_out_valid && m_axis.tready;

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .i_wr_en   (w_in_fire),
    .i_rd_en   (w_out_fire),
    .o_wr_ptr  (w_wr_ptr),
    .o_rd_ptr  (w_rd_ptr),
    .o_count   (w_count),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  always_comb begin
    w_wr_beat       = '0;
    w_wr_beat.tlast = s_axis.tlast;
    w_wr_beat.tkeep = s_axis.tkeep;
    w_wr_beat.tstrb = s_axis.tstrb;
    w_wr_beat.tdata = s_axis.tdata;
    w_wr_beat.tdest = s_axis.tdest;
    w_wr_beat.tuser = s_axis.tuser;
    w_wr_beat.tid   = s_axis.tid;
  end

  // Storage is intentionally not reset; pointers alone define validity
  always_ff @(posedge CLK) begin
    if (w_in_fire) r_mem[w_wr_ptr] <= w_wr_beat;
  end

  assign w_rd_beat     = r_mem[w_rd_ptr];
  assign m_axis.tlast  = w_rd_beat.tlast;
  assign m_axis.tkeep  = w_rd_beat.tkeep;
  assign m_axis.tstrb  = w_rd_beat.tstrb;
  assign m_axis.tdata  = w_rd_beat.tdata;
  assign m_axis.tdest  = w_rd_beat.tdest;
  assign m_axis.tuser  = w_rd_beat.tuser;
  assign m_axis.tid    = w_rd_beat.tid;
  assign m_axis.tvalid = w_out_valid;

`ifdef AXIS_EGRESS_PACKET_MODE_EN
  logic [CNT_W-1:0] r_pkt_cnt;
  logic             r_release;
  logic             w_in_last;
  logic             w_out_last;

  assign w_in_last  = w_in_fire && s_axis.tlast;
  assign w_out_last = w_out_fire && w_rd_beat.tlast;

  // Release lets an oversize packet cut through until its tlast leaves
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pkt_cnt <= '0;
      r_release <= 1'b0;
    end else begin
      if (w_in_last && !w_out_last)      r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      else if (!w_in_last && w_out_last) r_pkt_cnt <= r_pkt_cnt - CNT_W'(1);
      if (w_out_last)                          r_release <= 1'b0;
      else if (w_full && (r_pkt_cnt == '0))    r_release <= 1'b1;
    end
  end

  assign w_out_valid = !w_empty && ((r_pkt_cnt != '0) || w_full || r_release);
`else
  assign w_out_valid = !w_empty;
`endif

  assign occupancy   = w_count;
  assign almost_full = (w_count >= CNT_W'(AFULL_THRESH));

endmodule

// File: tb/tb_axis_egress_fifo.sv
// Directed self-checking bench for axis_egress_fifo (DEPTH=16, AFULL_THRESH=12).
module tb_axis_egress_fifo;
  import axi4_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [4:0] occ;
  logic       af;
  int         total = 0;
  int         bad = 0;
  axis_beat_t got[$];
  axis_beat_t exp_q[$];
  axis_beat_t m_b;

  axi_stream_interface s_if ();
  axi_stream_interface m_if ();

  axis_egress_fifo #(.DEPTH(16), .AFULL_THRESH(12)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .occupancy   (occ),
    .almost_full (af)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    m_b       = '0;
    m_b.tlast = m_if.tlast;
    m_b.tkeep = m_if.tkeep;
    m_b.tstrb = m_if.tstrb;
    m_b.tdata = m_if.tdata;
    m_b.tdest = m_if.tdest;
    m_b.tuser = m_if.tuser;
    m_b.tid   = m_if.tid;
  end

  // Output monitor: a handshake seen mid-cycle fires at the next rising edge
  always @(negedge CLK) begin
    if (RST_N && m_if.tvalid && m_if.tready) got.push_back(m_b);
  end

  function automatic axis_beat_t mk_beat(int idx, bit last);
    axis_beat_t b;
    b.tlast = last;
    b.tdata = {16'hBEEF, 16'(idx), 16'hF00D ^ 16'(idx * 3), 16'(idx)};
    b.tstrb = 8'(idx * 7);
    b.tkeep = ~8'(idx * 7);
    b.tdest = 4'(idx);
    b.tuser = 8'(idx + 5);
    b.tid   = 8'(idx) ^ 8'h5A;
    return b;
  endfunction

  task automatic drive_beat(input axis_beat_t b);
    s_if.tlast = b.tlast;
    s_if.tkeep = b.tkeep;
    s_if.tstrb = b.tstrb;
    s_if.tdata = b.tdata;
    s_if.tdest = b.tdest;
    s_if.tuser = b.tuser;
    s_if.tid   = b.tid;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_if.tvalid); end
    total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL reset_tready: got %b want 1", s_if.tready); end
    total++; if (occ !== 5'd0) begin bad++; $display("FAIL reset_occ: got %0d want 0", occ); end
    total++; if (af !== 1'b0) begin bad++; $display("FAIL reset_afull: got %b want 0", af); end
  endtask

  task automatic test_single();
    axis_beat_t b;
    b = '0;
    b.tlast = 1'b1;
    b.tkeep = 8'hFF;
    b.tstrb = 8'hFF;
    b.tdata = 64'h1122334455667788;
    b.tid   = 8'd3;
    got.delete();
    m_if.tready = 1'b1;
    drive_beat(b);
    s_if.tvalid = 1'b1;
    tick();
    s_if.tvalid = 1'b0;
    total++; if (m_if.tvalid !== 1'b1) begin bad++; $display("FAIL single_tvalid: got %b want 1", m_if.tvalid); end
    total++; if (m_b !== b) begin bad++; $display("FAIL single_beat: got %h want %h", m_b, b); end
    total++; if (occ !== 5'd1) begin bad++; $display("FAIL single_occ1: got %0d want 1", occ); end
    tick();
    total++; if (occ !== 5'd0) begin bad++; $display("FAIL single_occ0: got %0d want 0", occ); end
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL single_empty: got %b want 0", m_if.tvalid); end
    total++; if (got.size() != 1) begin bad++; $display("FAIL single_count: got %0d want 1", got.size()); end
  endtask

  task automatic test_fill_drain();
    axis_beat_t b;
    int idx;
    int cyc;
    bit acc;
    got.delete();
    exp_q.delete();
    m_if.tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b = mk_beat(i, (i % 4) == 3);
      drive_beat(b);
      s_if.tvalid = 1'b1;
      exp_q.push_back(b);
      tick();
      total++; if (occ !== 5'(i + 1)) begin bad++; $display("FAIL fill_occ[%0d]: got %0d want %0d", i, occ, i + 1); end
      total++; if (af !== ((i + 1) >= 12)) begin bad++; $display("FAIL fill_afull[%0d]: got %b want %b", i, af, (i + 1) >= 12); end
    end
    total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL full_tready: got %b want 0", s_if.tready); end
    b = mk_beat(16, 1'b0);
    drive_beat(b);
    repeat (3) tick();
    total++; if (occ !== 5'd16 || s_if.tready !== 1'b0) begin bad++; $display("FAIL full_hold: got occ=%0d tready=%b want occ=16 tready=0", occ, s_if.tready); end
    idx = 16;
    cyc = 0;
    while (idx < 36 && cyc < 1000) begin
      m_if.tready = 1'($urandom_range(0, 1));
      acc = s_if.tready;
      tick();
      cyc++;
      if (acc) begin
        exp_q.push_back(b);
        idx++;
        if (idx < 36) begin
          b = mk_beat(idx, (idx % 4) == 3);
          drive_beat(b);
        end else begin
          s_if.tvalid = 1'b0;
        end
      end
    end
    total++; if (idx != 36) begin bad++; $display("FAIL drain_push_timeout: got %0d want 36", idx); end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    cyc = 0;
    while (got.size() < 36 && cyc < 200) begin tick(); cyc++; end
    total++; if (got.size() != 36) begin bad++; $display("FAIL drain_count: got %0d want 36", got.size()); end
    for (int i = 0; i < 36; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL drain_beat[%0d]: got %h want %h", i, got[i], exp_q[i]); end
      end
    end
    total++; if (occ !== 5'd0) begin bad++; $display("FAIL drain_occ: got %0d want 0", occ); end
  endtask

  task automatic test_simultaneous();
    axis_beat_t a;
    axis_beat_t b;
    got.delete();
    a = mk_beat(50, 1'b1);
    b = mk_beat(51, 1'b1);
    m_if.tready = 1'b0;
    drive_beat(a);
    s_if.tvalid = 1'b1;
    tick();
    drive_beat(b);
    m_if.tready = 1'b1;
    tick();
    s_if.tvalid = 1'b0;
    total++; if (occ !== 5'd1) begin bad++; $display("FAIL simul_occ: got %0d want 1", occ); end
    total++; if (m_if.tvalid !== 1'b1) begin bad++; $display("FAIL simul_tvalid: got %b want 1", m_if.tvalid); end
    total++; if (m_b !== b) begin bad++; $display("FAIL simul_next: got %h want %h", m_b, b); end
    tick();
    total++; if (occ !== 5'd0) begin bad++; $display("FAIL simul_occ0: got %0d want 0", occ); end
    total++; if (got.size() != 2) begin bad++; $display("FAIL simul_count: got %0d want 2", got.size()); end
    else begin
      total++; if (got[0] !== a || got[1] !== b) begin bad++; $display("FAIL simul_order: got %h,%h want %h,%h", got[0], got[1], a, b); end
    end
  endtask

  task automatic test_reset_mid_packet();
    int cyc;
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_beat(mk_beat(60 + i, 1'b0));
      tick();
    end
    s_if.tvalid = 1'b0;
    total++; if (occ !== 5'd3) begin bad++; $display("FAIL rmid_occ3: got %0d want 3", occ); end
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL rmid_tvalid: got %b want 0", m_if.tvalid); end
    total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL rmid_tready: got %b want 1", s_if.tready); end
    total++; if (occ !== 5'd0) begin bad++; $display("FAIL rmid_occ: got %0d want 0", occ); end
    got.delete();
    exp_q.delete();
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_beat(mk_beat(70 + i, i == 4));
      exp_q.push_back(mk_beat(70 + i, i == 4));
      tick();
    end
    s_if.tvalid = 1'b0;
    cyc = 0;
    while (got.size() < 5 && cyc < 50) begin tick(); cyc++; end
    total++; if (got.size() != 5) begin bad++; $display("FAIL rmid_count: got %0d want 5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL rmid_beat[%0d]: got %h want %h", i, got[i], exp_q[i]); end
      end
    end
  endtask

`ifdef AXIS_EGRESS_PACKET_MODE_EN
  task automatic test_pkt_gap();
    got.delete();
    m_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(mk_beat(80 + i, i == 3));
      s_if.tvalid = 1'b1;
      tick();
      s_if.tvalid = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL pkt_hold[%0d]: got %b want 0", i, m_if.tvalid); end
          if (g < 2) tick();
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (m_if.tvalid !== 1'b1) begin bad++; $display("FAIL pkt_burst[%0d]: got %b want 1", i, m_if.tvalid); end
      tick();
    end
    total++; if (got.size() != 4) begin bad++; $display("FAIL pkt_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== mk_beat(80 + i, i == 3)) begin bad++; $display("FAIL pkt_beat[%0d]: got %h want %h", i, got[i], mk_beat(80 + i, i == 3)); end
      end
    end
  endtask

  task automatic test_pkt_oversize();
    int idx;
    int cyc;
    bit acc;
    got.delete();
    m_if.tready = 1'b1;
    idx = 0;
    cyc = 0;
    drive_beat(mk_beat(100, 1'b0));
    s_if.tvalid = 1'b1;
    while (idx < 20 && cyc < 500) begin
      acc = s_if.tready;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 20) drive_beat(mk_beat(100 + idx, idx == 19));
        else s_if.tvalid = 1'b0;
      end
    end
    s_if.tvalid = 1'b0;
    cyc = 0;
    while (got.size() < 20 && cyc < 200) begin tick(); cyc++; end
    total++; if (got.size() != 20) begin bad++; $display("FAIL big_count: got %0d want 20", got.size()); end
    for (int i = 0; i < 20; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== mk_beat(100 + i, i == 19)) begin bad++; $display("FAIL big_beat[%0d]: got %h want %h", i, got[i], mk_beat(100 + i, i == 19)); end
      end
    end
  endtask
`endif

  initial begin
    RST_N       = 1'b0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    drive_beat('0);
    test_reset();
    test_single();
    test_fill_drain();
    test_simultaneous();
    test_reset_mid_packet();
`ifdef AXIS_EGRESS_PACKET_MODE_EN
    test_pkt_gap();
    test_pkt_oversize();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
